// File: rtl/phase_timer_pkg.sv
// phase_timer_pkg
//   Elaboration-time helpers shared by the phase_timer files.
//   max_int   : larger of two integers.
//   cnt_width : counter width that can hold the longest period length.
package phase_timer_pkg;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  function automatic int cnt_width(input int interim_len, input int full_len);
    return $clog2(max_int(interim_len, full_len) + 1);
  endfunction

endpackage

// File: rtl/phase_timer_mod_counter.sv
// mod_counter
//   Synchronous up-counter with clear, count enable and a run-time terminal
//   count. When counting at the terminal value it wraps to zero and flags it.
//   Ports:
//     clk   in   clock, rising edge
//     rst   in   synchronous active-high reset (clears count)
//     clr   in   synchronous clear, same effect as rst
//     inc   in   count enable
//     term  in   terminal count (period length minus one)
//     cnt   out  current count
//     wrap  out  high when this cycle's increment wraps term -> 0
module mod_counter #(
  parameter int W = 5
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         inc,
  input  logic [W-1:0] term,
  output logic [W-1:0] cnt,
  output logic         wrap
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  assign wrap = inc && (cnt_q == term);
  assign cnt  = cnt_q;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (inc) begin
      // Wrap only at term, so the count never runs past the period end.
      cnt_d = wrap ? '0 : cnt_q + W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/phase_timer.sv
// phase_timer
//   Enable-gated periodic pulse generator. The first period after enable is
//   INTERIM_CYCLE long, all later ones FULL_CYCLE long; o is high for the
//   first OUTPUT_UP_PERIOD cycles of each period. Dropping en aborts and
//   restarts from the interim period on the next enable.
//   Ports:
//     clk  in   clock, rising edge
//     rst  in   synchronous active-high reset (priority over en)
//     en   in   run enable
//     o    out  pulse output, decoded from registers only
module phase_timer
  import phase_timer_pkg::*;
#(
  parameter int INTERIM_CYCLE    = 20,
  parameter int FULL_CYCLE       = 23,
  parameter int OUTPUT_UP_PERIOD = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  output logic o
);

  localparam int CNT_W = cnt_width(INTERIM_CYCLE, FULL_CYCLE);

  localparam logic [CNT_W-1:0] TERM_INTERIM = CNT_W'(INTERIM_CYCLE - 1);
  localparam logic [CNT_W-1:0] TERM_FULL    = CNT_W'(FULL_CYCLE - 1);
  localparam logic [CNT_W-1:0] UP_LEN       = CNT_W'(OUTPUT_UP_PERIOD);

  if (INTERIM_CYCLE < 1 || FULL_CYCLE < 1 || OUTPUT_UP_PERIOD < 1 ||
      OUTPUT_UP_PERIOD > INTERIM_CYCLE || OUTPUT_UP_PERIOD > FULL_CYCLE) begin : g_bad_params
    $fatal(1, "phase_timer: illegal INTERIM_CYCLE/FULL_CYCLE/OUTPUT_UP_PERIOD");
  end

  logic             active_q, active_d;
  logic             first_q, first_d;
  logic             restart;
  logic             wrap;
  logic [CNT_W-1:0] term;
  logic [CNT_W-1:0] cnt;

  // Disabled or not yet started: hold the counter at zero and re-arm the
  // interim period. rst is folded in so the counter clears with it.
  assign restart = rst || !en || !active_q;
  assign term    = first_q ? TERM_INTERIM : TERM_FULL;

  mod_counter #(
    .W (CNT_W)
  ) u_cnt (
    .clk  (clk),
    .rst  (rst),
    .clr  (restart),
    .inc  (!restart),
    .term (term),
    .cnt  (cnt),
    .wrap (wrap)
  );

  always_comb begin
    active_d = active_q;
    first_d  = first_q;
    if (!en) begin
      active_d = 1'b0;
      first_d  = 1'b1;
    end else if (!active_q) begin
      active_d = 1'b1;
      first_d  = 1'b1;
    end else if (wrap) begin
      first_d  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      active_q <= 1'b0;
      first_q  <= 1'b1;
    end else begin
      active_q <= active_d;
      first_q  <= first_d;
    end
  end

  assign o = active_q && (cnt < UP_LEN);

endmodule

// File: tb/tb_phase_timer.sv
module tb_phase_timer;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic en  = 1'b0;
  logic o, o_a, o_b;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  phase_timer dut (
    .clk (clk), .rst (rst), .en (en), .o (o)
  );

  // Whole period is high phase: o continuous while enabled.
  phase_timer #(
    .INTERIM_CYCLE (3), .FULL_CYCLE (3), .OUTPUT_UP_PERIOD (3)
  ) dut_a (
    .clk (clk), .rst (rst), .en (en), .o (o_a)
  );

  // One-cycle periods: o high every enabled cycle.
  phase_timer #(
    .INTERIM_CYCLE (1), .FULL_CYCLE (1), .OUTPUT_UP_PERIOD (1)
  ) dut_b (
    .clk (clk), .rst (rst), .en (en), .o (o_b)
  );

  // Expected o for default 20/23/16, i = cycles since the enabling edge (1-based).
  function automatic logic exp_o(input int i);
    if (i <= 20) return (i <= 16);
    return (((i - 21) % 23) < 16);
  endfunction

  function automatic int exp_cnt(input int i);
    if (i <= 20) return i - 1;
    return (i - 21) % 23;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  task automatic chk_edges(input string tag, input logic expv);
    chk({tag, "/o_a"}, {31'd0, o_a}, {31'd0, expv});
    chk({tag, "/o_b"}, {31'd0, o_b}, {31'd0, expv});
  endtask

  initial begin
    // Reset with en low
    rst = 1'b1; en = 1'b0;
    tick();
    rst = 1'b0;
    chk("reset/o", {31'd0, o}, 32'd0);
    chk("reset/cnt", 32'(dut.cnt), 32'd0);
    chk_edges("reset", 1'b0);
    for (int i = 1; i <= 4; i++) begin
      tick();
      chk($sformatf("idle/o[%0d]", i), {31'd0, o}, 32'd0);
    end

    // Enable run, 30 cycles
    en = 1'b1;
    for (int i = 1; i <= 30; i++) begin
      tick();
      chk($sformatf("run/o[%0d]", i), {31'd0, o}, {31'd0, exp_o(i)});
      chk_edges($sformatf("run[%0d]", i), 1'b1);
    end
    en = 1'b0;
    tick();
    chk("drop/o", {31'd0, o}, 32'd0);
    chk("drop/cnt", 32'(dut.cnt), 32'd0);
    chk_edges("drop", 1'b0);

    // Gap, then re-enable for 10 cycles (drop lands mid-high-phase)
    for (int i = 1; i <= 14; i++) begin
      tick();
      chk($sformatf("gap/o[%0d]", i), {31'd0, o}, 32'd0);
    end
    en = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      tick();
      chk($sformatf("reen/o[%0d]", i), {31'd0, o}, {31'd0, exp_o(i)});
      chk($sformatf("reen/cnt[%0d]", i), 32'(dut.cnt), 32'(exp_cnt(i)));
    end
    en = 1'b0;
    tick();
    chk("reen_drop/o", {31'd0, o}, 32'd0);
    tick();

    // Long run, 100 cycles: periods 20, 23, 23, ...
    en = 1'b1;
    for (int i = 1; i <= 100; i++) begin
      tick();
      chk($sformatf("long/o[%0d]", i), {31'd0, o}, {31'd0, exp_o(i)});
      chk($sformatf("long/cnt[%0d]", i), 32'(dut.cnt), 32'(exp_cnt(i)));
      chk_edges($sformatf("long[%0d]", i), 1'b1);
    end

    // Reset while enabled, mid-high-phase (cnt = 10 here)
    rst = 1'b1;
    tick();
    chk("rst_pri/o", {31'd0, o}, 32'd0);
    chk("rst_pri/cnt", 32'(dut.cnt), 32'd0);
    chk_edges("rst_pri", 1'b0);
    rst = 1'b0;
    for (int i = 1; i <= 25; i++) begin
      tick();
      chk($sformatf("after_rst/o[%0d]", i), {31'd0, o}, {31'd0, exp_o(i)});
      chk($sformatf("after_rst/cnt[%0d]", i), 32'(dut.cnt), 32'(exp_cnt(i)));
    end
    en = 1'b0;
    tick();
    chk("final/o", {31'd0, o}, 32'd0);
    chk_edges("final", 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
